// File: rtl/mfp_eic_signal_conditioner_pkg.sv
// Shared EIC constants and debounce decision helper.
// Channel count, synchronizer depth and debounce counter width live here.
package mfp_eic_signal_conditioner_pkg;

  localparam int EIC_CHANNELS    = 8;
  localparam int EIC_SYNC_STAGES = 2;
  localparam int EIC_DB_WIDTH    = 16;

  typedef enum logic [1:0] {
    DB_FOLLOW,
    DB_HOLD,
    DB_COUNT,
    DB_COMMIT
  } db_action_e;

  // Precedence: bypass, then agreement, then limit test.
  function automatic db_action_e db_action(
    input logic en,
    input logic mismatch,
    input logic at_limit
  );
    db_action_e a;
    if (!en)            a = DB_FOLLOW;
    else if (!mismatch) a = DB_HOLD;
    else if (!at_limit) a = DB_COUNT;
    else                a = DB_COMMIT;
    return a;
  endfunction

endpackage

// File: rtl/mfp_eic_signal_conditioner_debounce_channel.sv
// One interrupt line: synchronizer, debounce counter,
// registered output bit and change strobe.
module eic_debounce_channel
  import mfp_eic_signal_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = EIC_SYNC_STAGES,
  parameter int DB_WIDTH    = EIC_DB_WIDTH
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                raw,
  input  logic                db_enable,
  input  logic [DB_WIDTH-1:0] db_limit,
  output logic                signal,
  output logic                signal_change
);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_WIDTH-1:0]    cnt;
  logic [DB_WIDTH-1:0]    cnt_next;
  logic                   sig_next;
  logic                   s;
  db_action_e             action;

  assign s = sync[SYNC_STAGES-1];

  // >= keeps a counter from stranding when the limit drops mid-count.
  assign action = db_action(db_enable, s != signal, cnt >= db_limit);

  always_comb begin
    sig_next = signal;
    cnt_next = cnt;
    unique case (action)
      DB_FOLLOW: begin
        sig_next = s;
        cnt_next = '0;
      end
      DB_HOLD: begin
        cnt_next = '0;
      end
      DB_COUNT: begin
        cnt_next = cnt + DB_WIDTH'(1);
      end
      DB_COMMIT: begin
        sig_next = s;
        cnt_next = '0;
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync          <= '0;
      cnt           <= '0;
      signal        <= 1'b0;
      signal_change <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], raw};
      cnt           <= cnt_next;
      signal        <= sig_next;
      signal_change <= sig_next ^ signal;
    end
  end

endmodule

// File: rtl/mfp_eic_signal_conditioner.sv
// EIC input conditioner: per-channel sync + debounce
// feeding the core's signal bus.
module mfp_eic_signal_conditioner
  import mfp_eic_signal_conditioner_pkg::*;
#(
  parameter int CHANNELS    = EIC_CHANNELS,
  parameter int SYNC_STAGES = EIC_SYNC_STAGES,
  parameter int DB_WIDTH    = EIC_DB_WIDTH
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] signal_raw,
  input  logic [CHANNELS-1:0] db_enable,
  input  logic [DB_WIDTH-1:0] db_limit,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] signal_change
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    eic_debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_WIDTH   (DB_WIDTH)
    ) u_ch (
      .CLK          (CLK),
      .RESET        (RESET),
      .raw          (signal_raw[i]),
      .db_enable    (db_enable[i]),
      .db_limit     (db_limit),
      .signal       (signal[i]),
      .signal_change(signal_change[i])
    );
  end

endmodule

// File: tb/tb_mfp_eic_signal_conditioner.sv
// Directed bench with an event scoreboard keyed on signal_change.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_mfp_eic_signal_conditioner;
  import mfp_eic_signal_conditioner_pkg::*;

  localparam int CH = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [CH-1:0] signal_raw;
  logic [CH-1:0] db_enable;
  logic [15:0]   db_limit;
  logic [CH-1:0] signal;
  logic [CH-1:0] signal_change;

  typedef struct {
    int            cyc;
    logic [CH-1:0] sig;
    logic [CH-1:0] chg;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic [CH-1:0] exp_sig = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            n;

  mfp_eic_signal_conditioner #(
    .CHANNELS   (CH),
    .SYNC_STAGES(2),
    .DB_WIDTH   (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .signal_raw   (signal_raw),
    .db_enable    (db_enable),
    .db_limit     (db_limit),
    .signal       (signal),
    .signal_change(signal_change)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic push(input int at, input logic [CH-1:0] nv);
    ev_t e;
    e.cyc   = at;
    e.sig   = nv;
    e.chg   = nv ^ exp_sig;
    exp_sig = nv;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b0 && signal_change !== '0) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_change: got chg=%b sig=%b (cycle %0d)",
                 signal_change, signal, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_cycle", cyc, mon_e.cyc);
        check("ev_signal", int'(signal), int'(mon_e.sig));
        check("ev_change", int'(signal_change), int'(mon_e.chg));
      end
    end
  end

  initial begin
    RESET      = 1'b1;
    signal_raw = '1;
    db_enable  = '0;
    db_limit   = 16'd0;

    // 1: reset with raw high, then unfiltered release
    tick(3);
    check("reset_signal", int'(signal), 0);
    check("reset_change", int'(signal_change), 0);
    RESET = 1'b0;
    push(cyc + 3, 4'hF);
    tick(6);

    // 2: filtered rise of ch0 with L=4
    signal_raw = 4'hE;
    push(cyc + 3, 4'hE);
    tick(5);
    db_enable = 4'b0001;
    db_limit  = 16'd4;
    tick(2);
    signal_raw = 4'hF;
    push(cyc + 7, 4'hF);
    tick(10);

    // 3: filtered fall, 4-cycle pulse rejected, 5-cycle pulse passes
    signal_raw = 4'hE;
    push(cyc + 7, 4'hE);
    tick(10);
    signal_raw = 4'hF;
    tick(4);
    signal_raw = 4'hE;
    tick(10);
    signal_raw = 4'hF;
    push(cyc + 7, 4'hF);
    tick(5);
    signal_raw = 4'hE;
    push(cyc + 7, 4'hE);
    tick(12);

    // 4: unfiltered ch1 toggling with a large limit
    db_limit = 16'd100;
    for (int i = 0; i < 4; i++) begin
      signal_raw = signal_raw ^ 4'b0010;
      push(cyc + 3, signal_raw);
      tick(3);
    end
    tick(6);

    // 5: limit lowered below the running count
    db_limit   = 16'd50;
    signal_raw = 4'hF;
    n = cyc;
    tick(32);
    db_limit = 16'd10;
    push(n + 33, 4'hF);
    tick(5);

    // 6: reset mid-count discards the partial count
    signal_raw = 4'hE;
    push(cyc + 13, 4'hE);
    tick(16);
    db_limit   = 16'd8;
    signal_raw = 4'hF;
    tick(5);
    RESET = 1'b1;
    tick(2);
    check("midreset_signal", int'(signal), 0);
    check("midreset_change", int'(signal_change), 0);
    check("midreset_queue", exp_q.size(), 0);
    exp_sig = '0;
    RESET = 1'b0;
    n = cyc;
    push(n + 3, 4'hE);
    push(n + 11, 4'hF);
    tick(15);

    check("final_queue", exp_q.size(), 0);
    check("final_signal", int'(signal), 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
